// File: rtl/ctrl_sequencer.sv
// Control FSM for the simple CPU datapath: latches instructions into IR and walks the execution states.
// Optional `CTRL_SEQ_PERF_CNT_EN adds a 16-bit retired-instruction counter output.
module ctrl_sequencer #(
    parameter int unsigned LOAD_WAIT = 0,
    parameter int unsigned IR_W      = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IR_W-1:0] instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic            hold,
    output logic [4:0]      state,
    output logic [IR_W-1:0] ir,
    output logic            alu_sub,
    output logic            done,
    output logic            illegal
`ifdef CTRL_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]     retired_cnt
`endif
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00000,
        LOAD  = 5'b00001,
        MOV   = 5'b00010,
        AR_A  = 5'b00011,
        AR_G  = 5'b00100,
        AR_WB = 5'b00101,
        LWAIT = 5'b00110
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_MOV  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011
    } opcode_e;

    localparam logic [3:0] WAIT_INIT = (LOAD_WAIT > 0) ? 4'(LOAD_WAIT - 1) : 4'd0;

    state_e          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic [2:0]      op_in;

    assign op_in       = instr[IR_W-1 -: 3];
    assign instr_ready = (state_q == IDLE) && !hold;
    assign state       = state_q;
    assign ir          = ir_q;
    assign illegal     = illegal_q;
    assign alu_sub     = (ir_q[IR_W-1 -: 3] == OP_SUB);
    assign done        = (state_q == LOAD) || (state_q == MOV) || (state_q == AR_WB);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        // hold freezes everything, including a pending illegal pulse
        if (!hold) begin
            illegal_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        ir_d = instr;
                        if (op_in[2]) begin
                            illegal_d = 1'b1;
                        end else begin
                            case (op_in)
                                OP_LOAD: begin
                                    if (LOAD_WAIT > 0) begin
                                        state_d = LWAIT;
                                        cnt_d   = WAIT_INIT;
                                    end else begin
                                        state_d = LOAD;
                                    end
                                end
                                OP_MOV:  state_d = MOV;
                                default: state_d = AR_A;
                            endcase
                        end
                    end
                end
                LWAIT: begin
                    if (cnt_q == '0) state_d = LOAD;
                    else             cnt_d   = cnt_q - 4'd1;
                end
                AR_A:    state_d = AR_G;
                AR_G:    state_d = AR_WB;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef CTRL_SEQ_PERF_CNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (done && !hold) retired_d = retired_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer (LOAD_WAIT = 2): directed vector table, reset/hold sequence,
// and random traffic against a queue-based reference model.
module tb_ctrl_sequencer;

    localparam int LW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        hold;
    logic [4:0]  state;
    logic [22:0] ir;
    logic        alu_sub;
    logic        done;
    logic        illegal;
`ifdef CTRL_SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    ctrl_sequencer #(.LOAD_WAIT(LW), .IR_W(23)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .hold(hold),
        .state(state),
        .ir(ir),
        .alu_sub(alu_sub),
        .done(done),
        .illegal(illegal)
`ifdef CTRL_SEQ_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          hold;
        bit          valid;
        logic [22:0] instr;
        logic [4:0]  st;
        logic [22:0] ir;
        bit          rdy;
        bit          dn;
        bit          ill;
        bit          sub;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(bit h, bit v, logic [22:0] in, logic [4:0] st, logic [22:0] irx,
                                bit rdy, bit dn, bit ill, bit sub);
        vec_t r;
        r.hold = h; r.valid = v; r.instr = in; r.st = st; r.ir = irx;
        r.rdy = rdy; r.dn = dn; r.ill = ill; r.sub = sub;
        return r;
    endfunction

    // Reference model: each accepted instruction expands into its list of states.
    int          m_q[$];
    logic [22:0] m_ir;
    bit          m_ill;
    int          m_ret;

    function automatic void model_reset();
        m_q.delete();
        m_ir  = '0;
        m_ill = 1'b0;
        m_ret = 0;
    endfunction

    function automatic int m_state();
        return (m_q.size() > 0) ? m_q[0] : 0;
    endfunction

    function automatic void model_clock(bit h, bit v, logic [22:0] in);
        int op;
        if (h) return;
        m_ill = 1'b0;
        if (m_q.size() > 0) begin
            if (m_q[0] == 1 || m_q[0] == 2 || m_q[0] == 5) m_ret++;
            void'(m_q.pop_front());
        end else if (v) begin
            m_ir = in;
            op   = int'(in[22:20]);
            if (op >= 4) m_ill = 1'b1;
            else if (op == 0) begin
                for (int k = 0; k < LW; k++) m_q.push_back(6);
                m_q.push_back(1);
            end else if (op == 1) m_q.push_back(2);
            else begin
                m_q.push_back(3); m_q.push_back(4); m_q.push_back(5);
            end
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; hold = 1'b0; instr_valid = 1'b0; instr = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [22:0] in);
        instr = in; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    initial begin
        int s, e, op;

        tv[0]  = mk(0, 1, 23'h135000, 0, 23'h000000, 1, 0, 0, 0);
        tv[1]  = mk(0, 0, 23'h000000, 2, 23'h135000, 0, 1, 0, 0);
        tv[2]  = mk(0, 1, 23'h312000, 0, 23'h135000, 1, 0, 0, 0);
        tv[3]  = mk(0, 0, 23'h000000, 3, 23'h312000, 0, 0, 0, 1);
        tv[4]  = mk(1, 0, 23'h000000, 4, 23'h312000, 0, 0, 0, 1);
        tv[5]  = mk(1, 0, 23'h000000, 4, 23'h312000, 0, 0, 0, 1);
        tv[6]  = mk(0, 0, 23'h000000, 4, 23'h312000, 0, 0, 0, 1);
        tv[7]  = mk(0, 0, 23'h000000, 5, 23'h312000, 0, 1, 0, 1);
        tv[8]  = mk(0, 1, 23'h070000, 0, 23'h312000, 1, 0, 0, 1);
        tv[9]  = mk(0, 0, 23'h000000, 6, 23'h070000, 0, 0, 0, 0);
        tv[10] = mk(0, 0, 23'h000000, 6, 23'h070000, 0, 0, 0, 0);
        tv[11] = mk(0, 0, 23'h000000, 1, 23'h070000, 0, 1, 0, 0);
        tv[12] = mk(0, 1, 23'h500000, 0, 23'h070000, 1, 0, 0, 0);
        tv[13] = mk(1, 0, 23'h000000, 0, 23'h500000, 0, 0, 1, 0);
        tv[14] = mk(0, 0, 23'h000000, 0, 23'h500000, 1, 0, 1, 0);
        tv[15] = mk(0, 1, 23'h123000, 0, 23'h500000, 1, 0, 0, 0);
        tv[16] = mk(0, 1, 23'h145000, 2, 23'h123000, 0, 1, 0, 0);
        tv[17] = mk(0, 1, 23'h145000, 0, 23'h123000, 1, 0, 0, 0);
        tv[18] = mk(0, 0, 23'h000000, 2, 23'h145000, 0, 1, 0, 0);
        tv[19] = mk(0, 0, 23'h000000, 0, 23'h145000, 1, 0, 0, 0);

        // Directed table
        do_reset();
        for (int i = 0; i < 20; i++) begin
            hold = tv[i].hold; instr_valid = tv[i].valid; instr = tv[i].instr;
            @(negedge clk);
            chk($sformatf("tv%0d state", i),   32'(state),       32'(tv[i].st));
            chk($sformatf("tv%0d ir", i),      32'(ir),          32'(tv[i].ir));
            chk($sformatf("tv%0d ready", i),   32'(instr_ready), 32'(tv[i].rdy));
            chk($sformatf("tv%0d done", i),    32'(done),        32'(tv[i].dn));
            chk($sformatf("tv%0d illegal", i), 32'(illegal),     32'(tv[i].ill));
            chk($sformatf("tv%0d alu_sub", i), 32'(alu_sub),     32'(tv[i].sub));
            @(posedge clk); #1;
        end
        hold = 1'b0; instr_valid = 1'b0;

        // Async reset during AR_G of an add, then hold against a valid instruction
        do_reset();
        send(23'h212000);
        @(posedge clk); #1;
        chk("add in AR_G", 32'(state), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst state", 32'(state), 32'd0);
        chk("async rst ir",    32'(ir),    32'd0);
        chk("async rst done",  32'(done),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post rst ready", 32'(instr_ready), 32'd1);
        chk("post rst state", 32'(state),       32'd0);
        hold = 1'b1; instr_valid = 1'b1; instr = 23'h135000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("hold%0d state", i), 32'(state),       32'd0);
            chk($sformatf("hold%0d ready", i), 32'(instr_ready), 32'd0);
            chk($sformatf("hold%0d ir", i),    32'(ir),          32'd0);
        end
        @(posedge clk); #1 hold = 1'b0;
        @(posedge clk); #1 instr_valid = 1'b0;
        chk("after hold state", 32'(state), 32'd2);
        chk("after hold ir",    32'(ir),    32'h135000);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            hold = ($urandom_range(0, 4) == 0);
            if (!(instr_valid && hold)) begin
                instr_valid = $urandom_range(0, 1) == 1;
                op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
                instr = {3'(op), 20'($urandom)};
            end
            @(negedge clk);
            s = int'(state);
            e = m_state();
            chk($sformatf("rnd%0d state", c),   32'(s),           32'(e));
            chk($sformatf("rnd%0d ir", c),      32'(ir),          32'(m_ir));
            chk($sformatf("rnd%0d ready", c),   32'(instr_ready), 32'((e == 0) && !hold));
            chk($sformatf("rnd%0d done", c),    32'(done),        32'(e == 1 || e == 2 || e == 5));
            chk($sformatf("rnd%0d illegal", c), 32'(illegal),     32'(m_ill));
            chk($sformatf("rnd%0d alu_sub", c), 32'(alu_sub),     32'(m_ir[22:20] == 3'b011));
`ifdef CTRL_SEQ_PERF_CNT_EN
            chk($sformatf("rnd%0d retired", c), 32'(retired_cnt), 32'(m_ret[15:0]));
`endif
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; #1 rst_n = 1'b1;
                model_reset();
                chk($sformatf("rnd%0d rst state", c), 32'(state), 32'd0);
            end
            @(posedge clk);
            model_clock(hold, instr_valid, instr);
            #1;
        end
        hold = 1'b0; instr_valid = 1'b0;

`ifdef CTRL_SEQ_PERF_CNT_EN
        // Counter: illegal not counted, wrap from FFFF to 0 (preloaded near the top)
        do_reset();
        @(negedge clk);
        chk("retired reset", 32'(retired_cnt), 32'd0);
        @(posedge clk); #1;
        send(23'h135000);
        @(posedge clk); #1;
        chk("retired 1", 32'(retired_cnt), 32'd1);
        send(23'h500000);
        @(posedge clk); #1;
        chk("retired illegal", 32'(retired_cnt), 32'd1);
        dut.retired_q = 16'hFFFE;
        send(23'h135000);
        @(posedge clk); #1;
        chk("retired FFFF", 32'(retired_cnt), 32'hFFFF);
        send(23'h135000);
        @(posedge clk); #1;
        chk("retired wrap", 32'(retired_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
